cache_plru_array: RTL
=====================

CACHE_PLRU_ARRAY -- requirements
Module: cache_plru_array

Interface
REQ-001 SHALL have parameter N_WAY, default 8, way count (power of 2, 2..16).
REQ-002 SHALL have parameter N_SET, default 64, set count (power of 2, 2..256); WAY_W=log2(N_WAY), IDX_W=log2(N_SET), NODE=N_WAY-1.
REQ-003 SHALL have clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have flush_req  in  1  pulse; re-initialise all sets.
REQ-006 SHALL have init_busy  out  1  sweep in progress; lookups/updates not accepted.
REQ-007 SHALL have lkp_vld  in  1  victim lookup request.
REQ-008 SHALL have lkp_idx  in  IDX_W  set index of lookup.
REQ-009 SHALL have way_valid  in  N_WAY  line-valid bits of the looked-up set, sampled with lkp_vld.
REQ-010 SHALL have way_pwr_on  in  N_WAY  per-way enable (power-gated ways = 0), sampled with lkp_vld.
REQ-011 SHALL have lkp_rdy  out  1  equals ~init_busy.
REQ-012 SHALL have sel_vld  out  1  victim result valid, one cycle after accepted lookup.
REQ-013 SHALL have sel_way  out  WAY_W  chosen victim way.
REQ-014 SHALL have sel_empty  out  1  victim is an invalid enabled way.
REQ-015 SHALL have sel_err  out  1  no enabled way existed.
REQ-016 SHALL have upd_vld  in  1  access (hit or fill) to record.
REQ-017 SHALL have upd_idx  in  IDX_W, upd_way  in  WAY_W  set and way accessed.

Function
REQ-018 SHALL store NODE tree bits per set; node n has children 2n+1, 2n+2; node 0 is root.
REQ-019 SHALL treat node bit 1 as "LRU in lower-index half", 0 as "LRU in upper half".
REQ-020 SHALL on accepted update (upd_vld & ~init_busy) set every node on the path to upd_way to point away from it (lower-half access -> 0, upper-half access -> 1) in one cycle; off-path bits unchanged.
REQ-021 SHALL accept a lookup when lkp_vld & lkp_rdy and present sel_vld/sel_way/sel_empty/sel_err registered on the next cycle; sel_vld otherwise 0, sel_* hold last value.
REQ-022 SHALL select the lowest-index way with way_valid=0 & way_pwr_on=1 if any (sel_empty=1).
REQ-023 SHALL otherwise descend from root following node bits; if the indicated subtree has no enabled way, take the sibling subtree.
REQ-024 SHALL, when way_pwr_on is all zero, return sel_way=0, sel_err=1, sel_empty=0.
REQ-025 SHALL use a two-state FSM INIT/IDLE: INIT writes all-ones to set cnt, cnt 0..N_SET-1, one set per cycle, then IDLE; init_busy=1 exactly in INIT.
REQ-026 SHALL enter INIT with cnt=0 on flush_req in IDLE; flush_req during INIT restarts cnt at 0.
REQ-027 SHALL give flush_req priority over same-cycle upd_vld and lkp_vld (both dropped).
REQ-028 SHALL allow lookup and update in the same cycle, any indices.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force state=INIT, cnt=0, sel_vld=0, sel_way=0, sel_empty=0, sel_err=0; init_busy=1, lkp_rdy=0.
REQ-030 SHALL restart the sweep from cnt=0 if reset asserts mid-sweep; tree-bit contents need no reset.

Configuration
REQ-031 SHALL, with CACHE_PLRU_BYPASS_EN defined, forward a same-cycle update to an equal lkp_idx so the victim uses post-update bits.
REQ-032 SHALL, without CACHE_PLRU_BYPASS_EN, compute the victim from pre-update bits (update visible to lookups from next cycle).

Structure
REQ-033 SHALL place plru_node_t width, way-id and set-index types, and tree-update helper in shared package pygmy_typedef/cache_func.
REQ-034 SHALL factor victim selection (REQ-022..024) into combinational sub-module cache_plru_pick.

Verification (N_WAY=8, N_SET=16)
REQ-035 Reset release -> init_busy=1 for 16 cycles, then 0; first lookup, all valid/enabled -> sel_way=0.
REQ-036 Updates way0,way4 on idx3, lookup idx3 all valid -> sel_way=2; way_valid[5]=0 instead -> sel_way=5, sel_empty=1.
REQ-037 way_pwr_on=8'h0F, all valid, after update way0 -> victim in 1..3 never 4..7; way_pwr_on=0 -> sel_err=1, sel_way=0.
REQ-038 Same-cycle upd way0 and lookup idx5 -> bypass build sel_way=4, non-bypass build sel_way=0.
REQ-039 flush_req mid-traffic plus same-cycle upd_vld -> update dropped, 16 busy cycles, set returns to all-ones (sel_way=0).
REQ-040 rst_n asserted at cnt=7 of sweep -> outputs reset immediately, full 16-cycle sweep restarts after release.

Source files
------------

// File: rtl/cache_plru_array_pkg.sv
// Shared types and the tree-PLRU update helper for cache_plru_array.
// Widths are sized for the largest supported configuration (16 ways, 256 sets).
package cache_plru_array_pkg;

    localparam int MAX_WAY_W   = 4;
    localparam int PLRU_NODE_W = 15;
    localparam int MAX_IDX_W   = 8;

    typedef logic [PLRU_NODE_W-1:0] plru_node_t;
    typedef logic [MAX_WAY_W-1:0]   way_id_t;
    typedef logic [MAX_IDX_W-1:0]   set_idx_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } init_state_t;

    // Walk from the root towards 'way' and make every node on the path point
    // away from it: a lower-half access writes 0, an upper-half access writes 1.
    function automatic plru_node_t plru_touch(input plru_node_t bits,
                                              input way_id_t    way,
                                              input int         way_w);
        plru_node_t res;
        int         n;
        logic       dir;
        res = bits;
        n   = 0;
        for (int l = 0; l < MAX_WAY_W; l++) begin
            if (l < way_w) begin
                dir            = way[2'(way_w - 1 - l)];
                res[n[3:0]]    = dir;
                n              = dir ? (2 * n + 2) : (2 * n + 1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_plru_array_pick.sv
// Combinational victim picker: first free enabled way, else tree descent that
// skips subtrees without any powered way, else an error when nothing is powered.
module cache_plru_pick #(
    parameter  int N_WAY = 8,
    localparam int WAY_W = $clog2(N_WAY),
    localparam int NODE  = N_WAY - 1
) (
    input  logic [NODE-1:0]  tree,
    input  logic [N_WAY-1:0] way_valid,
    input  logic [N_WAY-1:0] way_pwr_on,
    output logic [WAY_W-1:0] pick_way,
    output logic             pick_empty,
    output logic             pick_err
);

    logic [N_WAY-1:0] free;
    logic [15:0]      tree_pad;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] tree_way;
    logic             free_any;

    assign free     = ~way_valid & way_pwr_on;
    assign tree_pad = 16'(tree);

    // Lowest-index invalid-but-powered way (scan high to low, last hit wins).
    always_comb begin
        free_any = 1'b0;
        free_way = '0;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (free[w[WAY_W-1:0]]) begin
                free_any = 1'b1;
                free_way = w[WAY_W-1:0];
            end
        end
    end

    // Descend the tree; a node bit of 1 sends us to the lower half unless that
    // half has no powered way, in which case the sibling half is taken.
    always_comb begin
        int               n;
        int               b;
        int               s;
        logic             up;
        logic [N_WAY-1:0] span;
        logic [N_WAY-1:0] m_lo;
        logic [N_WAY-1:0] m_hi;
        n    = 0;
        b    = 0;
        s    = 0;
        up   = 1'b0;
        span = '0;
        m_lo = '0;
        m_hi = '0;
        for (int l = 0; l < WAY_W; l++) begin
            s    = N_WAY >> (l + 1);
            span = (N_WAY'(1) << s) - N_WAY'(1);
            m_lo = span << b;
            m_hi = span << (b + s);
            up   = ~tree_pad[n[3:0]];
            if (up && ~|(way_pwr_on & m_hi)) begin
                up = 1'b0;
            end else if (!up && ~|(way_pwr_on & m_lo)) begin
                up = 1'b1;
            end
            if (up) begin
                b = b + s;
                n = 2 * n + 2;
            end else begin
                n = 2 * n + 1;
            end
        end
        tree_way = b[WAY_W-1:0];
    end

    // Final priority: no powered way, then free way, then tree victim.
    always_comb begin
        pick_way   = '0;
        pick_empty = 1'b0;
        pick_err   = 1'b0;
        if (~|way_pwr_on) begin
            pick_err = 1'b1;
        end else if (free_any) begin
            pick_way   = free_way;
            pick_empty = 1'b1;
        end else begin
            pick_way = tree_way;
        end
    end

endmodule

// File: rtl/cache_plru_array.sv
// Tree-PLRU state array with victim lookup, access update and flush sweep.
// Optional macro CACHE_PLRU_BYPASS_EN: a same-cycle update to the looked-up
// set is forwarded so the victim is computed from post-update tree bits.
module cache_plru_array
    import cache_plru_array_pkg::*;
#(
    parameter  int N_WAY = 8,
    parameter  int N_SET = 64,
    localparam int WAY_W = $clog2(N_WAY),
    localparam int IDX_W = $clog2(N_SET),
    localparam int NODE  = N_WAY - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req,
    output logic             init_busy,
    input  logic             lkp_vld,
    input  logic [IDX_W-1:0] lkp_idx,
    input  logic [N_WAY-1:0] way_valid,
    input  logic [N_WAY-1:0] way_pwr_on,
    output logic             lkp_rdy,
    output logic             sel_vld,
    output logic [WAY_W-1:0] sel_way,
    output logic             sel_empty,
    output logic             sel_err,
    input  logic             upd_vld,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [WAY_W-1:0] upd_way
);

    init_state_t      state;
    logic [IDX_W-1:0] cnt;
    logic [NODE-1:0]  tree_mem [N_SET];

    logic             lkp_acc;
    logic             upd_acc;
    logic [NODE-1:0]  upd_rd;
    logic [NODE-1:0]  upd_new;
    logic [NODE-1:0]  lkp_tree;
    logic [WAY_W-1:0] pick_way;
    logic             pick_empty;
    logic             pick_err;

    assign init_busy = (state == ST_INIT);
    assign lkp_rdy   = ~init_busy;
    // A flush in the same cycle wins over both lookup and update.
    assign lkp_acc   = lkp_vld & lkp_rdy & ~flush_req;
    assign upd_acc   = upd_vld & ~init_busy & ~flush_req;

    // Read-modify value for the accessed set.
    always_comb begin
        upd_rd  = tree_mem[upd_idx];
        upd_new = NODE'(plru_touch(plru_node_t'(upd_rd), way_id_t'(upd_way), WAY_W));
    end

    // Tree bits seen by the victim picker.
    always_comb begin
        lkp_tree = tree_mem[lkp_idx];
`ifdef CACHE_PLRU_BYPASS_EN
        if (upd_acc && (upd_idx == lkp_idx)) begin
            lkp_tree = upd_new;
        end
`endif
    end

    cache_plru_pick #(
        .N_WAY(N_WAY)
    ) u_pick (
        .tree       (lkp_tree),
        .way_valid  (way_valid),
        .way_pwr_on (way_pwr_on),
        .pick_way   (pick_way),
        .pick_empty (pick_empty),
        .pick_err   (pick_err)
    );

    // Init/idle sequencer: sweep every set once, restartable by flush or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (flush_req) begin
                        cnt <= '0;
                    end else if (cnt == IDX_W'(N_SET - 1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Tree storage: sweep writes all-ones, otherwise record accepted accesses.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            tree_mem[cnt] <= '1;
        end else if (upd_acc) begin
            tree_mem[upd_idx] <= upd_new;
        end
    end

    // Registered victim result; fields hold when no lookup is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_vld   <= 1'b0;
            sel_way   <= '0;
            sel_empty <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            sel_vld <= lkp_acc;
            if (lkp_acc) begin
                sel_way   <= pick_way;
                sel_empty <= pick_empty;
                sel_err   <= pick_err;
            end
        end
    end

endmodule
